change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 50000, clock cycles each coin-eject pulse is held high (1 ms at 50 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 50000, minimum low cycles between consecutive eject pulses.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to pay out change, level sampled each clk edge.
REQ-006 SHALL have port amount  input  4  change to return in coin units (0..15), sampled only when start is accepted.
REQ-007 SHALL have port coin2_empty  input  1  high when the 2-unit coin hopper is empty.
REQ-008 SHALL have port busy  output  1  high while a payout is in progress.
REQ-009 SHALL have port coin1_out  output  1  eject pulse for the 1-unit hopper.
REQ-010 SHALL have port coin2_out  output  1  eject pulse for the 2-unit hopper.
REQ-011 SHALL have port remaining  output  4  change still owed, for the change display.
REQ-012 SHALL have port done  output  1  one-cycle pulse at payout completion.

Function
REQ-013 SHALL implement FSM states IDLE, SELECT, PULSE, GAP, DONE.
REQ-014 IDLE: start=1 SHALL be accepted, loading remaining<=amount; next state SELECT if amount!=0, else DONE.
REQ-015 start SHALL be ignored in every state except IDLE; amount SHALL NOT be resampled mid-payout.
REQ-016 SELECT (one cycle): SHALL choose the 2-unit coin if remaining>=2 and coin2_empty=0, else the 1-unit coin; next state PULSE.
REQ-017 PULSE: the chosen coinN_out SHALL be high for exactly PULSE_CYCLES consecutive cycles, the other low. remaining SHALL decrement by the coin value (2 or 1) on the last PULSE cycle.
REQ-018 GAP: both coin outputs SHALL be low for exactly GAP_CYCLES cycles. Next state DONE if remaining==0, else SELECT.
REQ-019 coin2_empty SHALL be evaluated only in SELECT; changes during PULSE/GAP SHALL NOT affect the coin in flight.
REQ-020 coin1_out and coin2_out SHALL be registered, never high simultaneously, and free of glitches.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE. busy SHALL be 1 in SELECT, PULSE, GAP and DONE, and 0 in IDLE.
REQ-022 Total value ejected SHALL equal the accepted amount exactly; remaining SHALL never underflow.
REQ-023 First eject pulse SHALL rise on the 2nd clk edge after the edge that accepts start.
REQ-024 Timer SHALL be wide enough for max(PULSE_CYCLES, GAP_CYCLES) and SHALL restart at each PULSE/GAP entry.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, remaining=0, timer=0, busy=0, done=0, coin1_out=0, coin2_out=0.
REQ-026 rst asserted mid-pulse SHALL drop the active coin output immediately and abandon the payout, with no resume after release.
REQ-027 After rst release, the first accepted start SHALL behave identically to post-power-up.

Structure
REQ-028 State enum and coin value constants (COIN1_VAL=1, COIN2_VAL=2) SHALL live in the shared coffee machine package.
REQ-029 Pulse/gap timing SHALL be one sub-module, dispense_timer: load, count-down and expire flag, parameterized width.
REQ-030 The FSM and remaining register SHALL reside in change_dispenser; there SHALL be no other sub-modules.

Verification (PULSE_CYCLES=2, GAP_CYCLES=3)
REQ-031 amount=5, coin2_empty=0, start 1 cycle -> coin2, coin2, coin1 pulses, each 2 cycles high, separated by 3-cycle gaps; remaining steps 5,3,1,0; done once; busy low afterward.
REQ-032 amount=0, start -> no coin pulses, done one cycle after acceptance, busy high exactly 1 cycle.
REQ-033 amount=4, coin2_empty=1 -> four coin1 pulses, zero coin2 pulses, remaining steps 4,3,2,1,0.
REQ-034 amount=3, coin2_empty rises during the first coin2 PULSE -> that coin2 completes, then one coin1; total 3.
REQ-035 amount=15, rst pulsed during the 2nd PULSE -> coin output low in the same cycle; all outputs at reset values; a new start with amount=1 yields a single coin1 pulse.
REQ-036 start held high through an entire amount=2 payout -> one coin2 only; a second payout begins only on the first edge after return to IDLE.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared coffee machine definitions: the change dispenser FSM states and coin values.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } state_t;

    localparam logic [3:0] COIN1_VAL = 4'd1;
    localparam logic [3:0] COIN2_VAL = 4'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Down-counter for eject pulse and gap timing: load, count down to zero, flag expiry.
module dispense_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Loading N-1 makes the owning state last exactly N cycles.
    assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: ejects 2-unit coins while possible, 1-unit coins otherwise,
// with timed eject pulses and gaps, until the accepted amount has been paid.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 50000,
    parameter int GAP_CYCLES   = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] amount,
    input  logic       coin2_empty,
    output logic       busy,
    output logic       coin1_out,
    output logic       coin2_out,
    output logic [3:0] remaining,
    output logic       done
);

    localparam int MAX_CYC = max_int(PULSE_CYCLES, GAP_CYCLES);
    localparam int TW      = $clog2(MAX_CYC + 1);

    state_t          state;
    state_t          state_next;
    logic            use2;
    logic            use2_next;
    logic [3:0]      rem_next;
    logic [3:0]      coin_val;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_expired;

    dispense_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expired (tmr_expired)
    );

    // Coin outputs are registered copies of the PULSE state, so they trail it by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            use2      <= 1'b0;
            coin1_out <= 1'b0;
            coin2_out <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= rem_next;
            use2      <= use2_next;
            coin1_out <= (state == PULSE) && !use2;
            coin2_out <= (state == PULSE) && use2;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = remaining;
        use2_next  = use2;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        coin_val   = use2 ? COIN2_VAL : COIN1_VAL;
        case (state)
            IDLE: begin
                if (start) begin
                    rem_next   = amount;
                    state_next = (amount != 4'd0) ? SELECT : DONE;
                end
            end
            SELECT: begin
                // The hopper-empty flag is only looked at here; the coin in flight is fixed.
                use2_next  = (remaining >= COIN2_VAL) && !coin2_empty;
                tmr_load   = 1'b1;
                tmr_val    = TW'(PULSE_CYCLES - 1);
                state_next = PULSE;
            end
            PULSE: begin
                if (tmr_expired) begin
                    rem_next   = remaining - coin_val;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(GAP_CYCLES - 1);
                    state_next = GAP;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    state_next = (remaining == 4'd0) ? DONE : SELECT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
